// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg: shared AHB-Lite encodings and SRAM slave FSM states
package ahb_lite_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, NONSEQ, SEQ} htrans_t;
  typedef enum logic [2:0] {BYTE = 3'd0, HALF = 3'd1, WORD = 3'd2} hsize_t;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} slave_state_t;
endpackage

// File: rtl/ahb_sram_lane_decode.sv
// ahb_sram_lane_decode: byte-lane strobes and alignment check for one AHB beat
module ahb_sram_lane_decode
  import ahb_lite_pkg::*;
(
  input  logic [1:0] addr,
  input  logic [2:0] size,
  output logic [3:0] strb,
  output logic       misalign
);
  always_comb begin
    strb = size == BYTE ? 4'b0001 << addr :
           size == HALF ? (addr[1] ? 4'b1100 : 4'b0011) :
           size == WORD ? 4'hf : 4'h0;
    misalign = (size == HALF && addr[0]) || (size == WORD && addr != 2'b00);
  end
endmodule

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: word-organised SRAM behind an AHB-Lite slave port
// Define AHB_SRAM_WAIT_EN to insert WAIT_CYCLES wait states on every OKAY transfer.
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned HADDR_SIZE  = 16,
  parameter int unsigned HDATA_SIZE  = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [HDATA_SIZE-1:0] HRDATA
);
  localparam int unsigned AW = $clog2(MEM_DEPTH);
  logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];
  slave_state_t state, nxt;
  logic acc, bad, mis, dp_valid, dp_write, wr_now, ld_rd, unused_ok;
  logic [3:0] strb, dp_strb;
  logic [AW-1:0] widx, dp_idx, rd_idx;
  logic [HDATA_SIZE-1:0] rd_word;
  assign unused_ok = &{1'b0, HBURST, HPROT};
  ahb_sram_lane_decode u_dec (.addr(HADDR[1:0]), .size(HSIZE), .strb(strb), .misalign(mis));
`ifdef AHB_SRAM_WAIT_EN
  localparam slave_state_t OK_ST = S_WAIT;
  logic [3:0] cnt;
  always_ff @(posedge HCLK)
    if (HRESET) cnt <= 4'd0;
    else if (acc) cnt <= 4'(WAIT_CYCLES);
    else if (state == S_WAIT) cnt <= cnt - 4'd1;
  // Read data is fetched on the last wait cycle so it lands with HREADYOUT = 1.
  assign ld_rd  = state == S_WAIT && cnt == 4'd1 && !dp_write;
  assign rd_idx = dp_idx;
`else
  localparam slave_state_t OK_ST = S_IDLE;
  logic [3:0] cnt;
  assign cnt    = 4'd0;
  assign ld_rd  = acc && !bad && !HWRITE;
  assign rd_idx = widx;
`endif
  always_comb begin
    acc = HSEL && (HTRANS == NONSEQ || HTRANS == SEQ) && HREADY && HREADYOUT;
    bad = 32'(HADDR[HADDR_SIZE-1:2]) >= MEM_DEPTH || HSIZE > WORD || mis;
    widx = HADDR[AW+1:2];
    HREADYOUT = !(state == S_ERR1 || state == S_WAIT);
    HRESP = (state == S_ERR1 || state == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    wr_now = dp_valid && dp_write && HREADYOUT;
    nxt = state == S_ERR1 ? S_ERR2 :
          state == S_WAIT ? (cnt == 4'd1 ? S_IDLE : S_WAIT) :
          !acc ? S_IDLE : bad ? S_ERR1 : OK_ST;
    // A write completing in the same edge as a read accept is merged lane by lane.
    for (int i = 0; i < 4; i++)
      rd_word[8*i +: 8] = (wr_now && dp_idx == rd_idx && dp_strb[i]) ? HWDATA[8*i +: 8] : mem[rd_idx][8*i +: 8];
  end
  always_ff @(posedge HCLK)
    if (HRESET) begin
      state    <= S_IDLE;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_strb  <= 4'h0;
      HRDATA   <= '0;
    end else begin
      state <= nxt;
      if (HREADYOUT) dp_valid <= acc && !bad;
      if (acc) begin
        dp_write <= HWRITE;
        dp_idx   <= widx;
        dp_strb  <= strb;
      end
      if (ld_rd) HRDATA <= rd_word;
    end
  always_ff @(posedge HCLK)
    if (!HRESET && wr_now)
      for (int i = 0; i < 4; i++)
        if (dp_strb[i]) mem[dp_idx][8*i +: 8] <= HWDATA[8*i +: 8];
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb_ahb_lite_sram_slave: directed vectors for the AHB-Lite SRAM slave
module tb_ahb_lite_sram_slave;
`ifdef AHB_SRAM_WAIT_EN
  localparam int EXP_W = 2;
`else
  localparam int EXP_W = 0;
`endif
  logic clk = 1'b0, HRESET = 1'b1, HSEL = 1'b0, HWRITE = 1'b0;
  logic [15:0] HADDR = '0;
  logic [2:0] HSIZE = '0, HBURST = '0;
  logic [3:0] HPROT = '0;
  logic [1:0] HTRANS = '0;
  logic [31:0] HWDATA = '0, HRDATA;
  logic HREADY, HREADYOUT, HRESP;
  int n_chk = 0, n_fail = 0;
  logic [31:0] rd;
  logic rsp, r0, p0;
  int waits;
  assign HREADY = HREADYOUT;
  always #5 clk = ~clk;
  ahb_lite_sram_slave #(.MEM_DEPTH(256), .HADDR_SIZE(16), .HDATA_SIZE(32), .WAIT_CYCLES(2)) dut (
    .HCLK(clk), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic addr_ph(input logic w, input logic [15:0] a, input logic [2:0] sz);
    HSEL = 1'b1; HTRANS = 2'd2; HWRITE = w; HADDR = a; HSIZE = sz;
  endtask
  // Called #1 after a rising edge; returns #1 after the edge that ends the data phase.
  task automatic xfer(input logic w, input logic [15:0] a, input logic [2:0] sz, input logic [31:0] wd);
    addr_ph(w, a, sz);
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'd0; HWDATA = wd;
    r0 = HREADYOUT; p0 = HRESP; waits = 0;
    while (!HREADYOUT && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    rd = HRDATA; rsp = HRESP;
    @(posedge clk); #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 HRESET = 1'b0;
    chk("rst_ready", 32'(HREADYOUT), 32'd1);
    chk("rst_resp", 32'(HRESP), 32'd0);
    chk("rst_rdata", HRDATA, 32'h0);
    xfer(1'b1, 16'h0010, 3'd2, 32'hDEADBEEF);
    chk("wr_waits", waits, EXP_W);
    xfer(1'b0, 16'h0010, 3'd2, 32'h0);
    chk("rd_word", rd, 32'hDEADBEEF);
    chk("rd_resp", 32'(rsp), 32'd0);
    chk("rd_waits", waits, EXP_W);
    xfer(1'b1, 16'h0020, 3'd2, 32'h00000000);
    xfer(1'b1, 16'h0021, 3'd0, 32'h0000AA00);
    xfer(1'b1, 16'h0022, 3'd1, 32'h12340000);
    xfer(1'b0, 16'h0020, 3'd2, 32'h0);
    chk("lane_merge", rd, 32'h1234AA00);
    xfer(1'b1, 16'h0000, 3'd2, 32'hCAFEF00D);
    xfer(1'b0, 16'h0000, 3'd2, 32'h0);
    chk("rd_w0", rd, 32'hCAFEF00D);
    xfer(1'b0, 16'h0400, 3'd2, 32'h0);
    chk("oor_err1_ready", 32'(r0), 32'd0);
    chk("oor_err1_resp", 32'(p0), 32'd1);
    chk("oor_err2_resp", 32'(rsp), 32'd1);
    chk("oor_err_len", waits, 1);
    chk("oor_rdata_hold", rd, 32'hCAFEF00D);
    xfer(1'b1, 16'h0002, 3'd2, 32'hFFFFFFFF);
    chk("mis_word_err1", {r0, p0}, 32'b01);
    chk("mis_word_err2", 32'(rsp), 32'd1);
    xfer(1'b1, 16'h0001, 3'd1, 32'hFFFFFFFF);
    chk("mis_half_err", {r0, p0, rsp}, 32'b011);
    xfer(1'b1, 16'h0000, 3'd3, 32'hFFFFFFFF);
    chk("size3_err", {r0, p0, rsp}, 32'b011);
    xfer(1'b0, 16'h0000, 3'd2, 32'h0);
    chk("err_no_write", rd, 32'hCAFEF00D);
    chk("ok_after_err", 32'(rsp), 32'd0);
    HSEL = 1'b1; HTRANS = 2'd0; HADDR = 16'h0010;
    @(posedge clk); #1;
    chk("idle_ready", 32'(HREADYOUT), 32'd1);
    chk("idle_resp", 32'(HRESP), 32'd0);
    HTRANS = 2'd1;
    @(posedge clk); #1;
    chk("busy_ready", {HREADYOUT, HRESP}, 32'b10);
    chk("idle_rdata", HRDATA, 32'hCAFEF00D);
    HSEL = 1'b0;
    xfer(1'b1, 16'h0030, 3'd2, 32'hFFFFFFFF);
    xfer(1'b1, 16'h0034, 3'd2, 32'h11223344);
    addr_ph(1'b1, 16'h0030, 3'd2);
    @(posedge clk); #1;
    addr_ph(1'b0, 16'h0030, 3'd2); HWDATA = 32'h00000055;
    waits = 0;
    while (!HREADYOUT && waits < 20) begin @(posedge clk); #1; waits++; end
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'd0;
    waits = 0;
    while (!HREADYOUT && waits < 20) begin @(posedge clk); #1; waits++; end
    chk("b2b_word", HRDATA, 32'h00000055);
    chk("b2b_waits", waits, EXP_W);
    @(posedge clk); #1;
    addr_ph(1'b1, 16'h0036, 3'd1);
    @(posedge clk); #1;
    addr_ph(1'b0, 16'h0034, 3'd2); HWDATA = 32'hBEEF0000;
    waits = 0;
    while (!HREADYOUT && waits < 20) begin @(posedge clk); #1; waits++; end
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'd0;
    waits = 0;
    while (!HREADYOUT && waits < 20) begin @(posedge clk); #1; waits++; end
    chk("b2b_half", HRDATA, 32'hBEEF3344);
    @(posedge clk); #1;
    xfer(1'b1, 16'h0040, 3'd2, 32'h11111111);
    addr_ph(1'b1, 16'h0040, 3'd2);
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'd0; HWDATA = 32'h22222222; HRESET = 1'b1;
    @(posedge clk); #1;
    HRESET = 1'b0;
    chk("rst_mid_ready", 32'(HREADYOUT), 32'd1);
    chk("rst_mid_rdata", HRDATA, 32'h0);
    xfer(1'b0, 16'h0040, 3'd2, 32'h0);
    chk("rst_drop_write", rd, 32'h11111111);
`ifdef AHB_SRAM_WAIT_EN
    xfer(1'b0, 16'h0010, 3'd2, 32'h0);
    chk("wait_first", 32'(r0), 32'd0);
    chk("wait_len", waits, 2);
    chk("wait_data", rd, 32'hDEADBEEF);
    addr_ph(1'b0, 16'h0010, 3'd2);
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'd0;
    chk("wait_low", 32'(HREADYOUT), 32'd0);
    HRESET = 1'b1;
    @(posedge clk); #1;
    HRESET = 1'b0;
    chk("wait_rst_ready", 32'(HREADYOUT), 32'd1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
